// File: rtl/td4x_cpu_if.sv
// Instruction-fetch bus between the td4x core (master) and its program ROM (slave).
// instr_valid low stalls the core for that cycle.
interface td4x_cpu_if #(
  parameter int DW = 4,
  parameter int AW = 4
);
  localparam int IW = 4 + DW;

  logic [AW-1:0] pc_addr;
  logic [IW-1:0] instr_data;
  logic          instr_valid;

  modport master (output pc_addr, input instr_data, input instr_valid);
  modport slave  (input pc_addr, output instr_data, output instr_valid);
endinterface

// File: rtl/td4x_cpu.sv
// Single-cycle accumulator core: every enabled, valid fetch retires on the same edge.
// One adder serves ADD/MOV/IN/OUT; the data movers add zero, so their carry is 0.
module td4x_cpu #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  td4x_cpu_if.master        fetch,
  input  logic [DW-1:0]     port_i,
  output logic [DW-1:0]     port_o,
  output logic              cf,
  output logic              halted
);
  localparam int IW = 4 + DW;

  localparam logic [3:0] OP_ADD_AI = 4'b0000, OP_ADD_BI = 4'b0101, OP_ADD_AB = 4'b1000,
                         OP_MOV_AI = 4'b0011, OP_MOV_BI = 4'b0111, OP_MOV_AB = 4'b0001,
                         OP_MOV_BA = 4'b0100, OP_IN_A   = 4'b0010, OP_IN_B   = 4'b0110,
                         OP_OUT_B  = 4'b1001, OP_OUT_I  = 4'b1011, OP_JMP    = 4'b1111,
                         OP_JNC    = 4'b1110, OP_JC     = 4'b1100, OP_HLT    = 4'b1101,
                         OP_NOP    = 4'b1010;

  logic [DW-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          cf_q, cf_d, halt_q, halt_d;

  logic [IW-1:0] instr;
  logic [3:0]    op;
  logic [DW-1:0] im, src, opnd;
  logic [DW:0]   sum;
  logic [AW-1:0] tgt;
  logic          exec, wr_a, wr_b, wr_o, upd_cf, jmp, hlt;

  assign instr = fetch.instr_data;
  assign op    = instr[IW-1:IW-4];
  assign im    = instr[DW-1:0];
  assign exec  = ena & fetch.instr_valid & ~halt_q;
  assign sum   = {1'b0, src} + {1'b0, opnd};
  // Truncates when AW<=DW, zero-extends otherwise.
  assign tgt   = AW'(im);

  always_comb begin
    src = '0; opnd = '0;
    wr_a = 1'b0; wr_b = 1'b0; wr_o = 1'b0;
    upd_cf = 1'b1; jmp = 1'b0; hlt = 1'b0;
    case (op)
      OP_ADD_AI: begin src = a_q;    opnd = im;  wr_a = 1'b1; end
      OP_ADD_BI: begin src = b_q;    opnd = im;  wr_b = 1'b1; end
      OP_ADD_AB: begin src = a_q;    opnd = b_q; wr_a = 1'b1; end
      OP_MOV_AI: begin opnd = im;    wr_a = 1'b1; end
      OP_MOV_BI: begin opnd = im;    wr_b = 1'b1; end
      OP_MOV_AB: begin src = b_q;    wr_a = 1'b1; end
      OP_MOV_BA: begin src = a_q;    wr_b = 1'b1; end
      OP_IN_A:   begin src = port_i; wr_a = 1'b1; end
      OP_IN_B:   begin src = port_i; wr_b = 1'b1; end
      OP_OUT_B:  begin src = b_q;    wr_o = 1'b1; end
      OP_OUT_I:  begin opnd = im;    wr_o = 1'b1; end
      OP_JMP:    jmp = 1'b1;
      OP_JNC:    jmp = ~cf_q;
      OP_JC:     jmp = cf_q;
      OP_HLT:    hlt = 1'b1;
      OP_NOP:    upd_cf = 1'b0;
      default:   upd_cf = 1'b0;
    endcase
  end

  always_comb begin
    a_d = a_q; b_d = b_q; out_d = out_q;
    pc_d = pc_q; cf_d = cf_q; halt_d = halt_q;
    if (exec) begin
      if (wr_a)   a_d   = sum[DW-1:0];
      if (wr_b)   b_d   = sum[DW-1:0];
      if (wr_o)   out_d = sum[DW-1:0];
      if (upd_cf) cf_d  = sum[DW];
      if (hlt)      halt_d = 1'b1;
      else if (jmp) pc_d   = tgt;
      else          pc_d   = pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; out_q <= '0;
      pc_q <= '0; cf_q <= 1'b0; halt_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; out_q <= out_d;
      pc_q <= pc_d; cf_q <= cf_d; halt_q <= halt_d;
    end
  end

  assign fetch.pc_addr = pc_q;
  assign port_o        = out_q;
  assign cf            = cf_q;
  assign halted        = halt_q;
endmodule
